// File: rtl/write_addr_table_fwd_if.sv
// Write/read/response channels of the write-address table.
// The master side drives requests; the slave side is the table itself.
interface write_addr_table_fwd_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 14
);
    logic                  i_wr_en;
    logic                  o_wr_ready;
    logic [ADDR_WIDTH-1:0] iv_wr_addr;
    logic [DATA_WIDTH-1:0] iv_wr_data;
    logic                  i_rd_req_valid;
    logic                  o_rd_req_ready;
    logic [ADDR_WIDTH-1:0] iv_rd_addr;
    logic                  o_rd_rsp_valid;
    logic                  i_rd_rsp_ready;
    logic [DATA_WIDTH-1:0] ov_rd_rsp_data;
    logic                  o_init_done;
    logic [15:0]           ov_fwd_cnt;

    modport master (
        output i_wr_en, iv_wr_addr, iv_wr_data, i_rd_req_valid, iv_rd_addr, i_rd_rsp_ready,
        input  o_wr_ready, o_rd_req_ready, o_rd_rsp_valid, ov_rd_rsp_data, o_init_done, ov_fwd_cnt
    );

    modport slave (
        input  i_wr_en, iv_wr_addr, iv_wr_data, i_rd_req_valid, iv_rd_addr, i_rd_rsp_ready,
        output o_wr_ready, o_rd_req_ready, o_rd_rsp_valid, ov_rd_rsp_data, o_init_done, ov_fwd_cnt
    );
endinterface

// File: rtl/write_addr_table_fwd.sv
// Simple-dual-port write-address table with write-first forwarding, optional
// zero-fill sweep after reset and an in-order, backpressure-safe response FIFO.
module write_addr_table_fwd #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 14,
    parameter int RW_REG_NUM     = 1,
    parameter int INIT_ON_RESET  = 1,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RW_REG_NUM*32-1:0] rw_data,
    output logic [RW_REG_NUM*32-1:0] init_rw_data,
    write_addr_table_fwd_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = $clog2(RSP_FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [CW:0] OCC_LIMIT = RSP_FIFO_DEPTH[CW:0];

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
    localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic   RST_DONE  = (INIT_ON_RESET != 0) ? 1'b0 : 1'b1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  init_done_q, init_done_d;
    logic                  req_ready_q, req_ready_d;
    logic                  s1_vld_q, s1_fwd_q;
    logic [DATA_WIDTH-1:0] s1_fwd_data_q, ram_rd_q;
    logic [DATA_WIDTH-1:0] ram_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_FIFO_DEPTH];
    logic [PW-1:0]         fifo_rd_q, fifo_wr_q;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic                  rsp_valid_q;
    logic [15:0]           fwd_cnt_q;

    logic                  wr_fire_s, rd_fire_s, fwd_hit_s, push_s, pop_s;
    logic                  ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_waddr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s, push_data_s;
    logic [CW:0]           occ_s;
    logic                  unused_rw_s;

    // Test-select bits only matter for a hard RAM macro; the behavioural array ignores them.
    assign unused_rw_s  = ^rw_data;
    assign init_rw_data = '0;

    assign wr_fire_s   = bus.i_wr_en && init_done_q;
    assign rd_fire_s   = bus.i_rd_req_valid && req_ready_q;
    assign fwd_hit_s   = rd_fire_s && wr_fire_s && (bus.iv_wr_addr == bus.iv_rd_addr);
    assign push_s      = s1_vld_q;
    assign pop_s       = rsp_valid_q && bus.i_rd_rsp_ready;
    assign push_data_s = s1_fwd_q ? s1_fwd_data_q : ram_rd_q;

    // RAM write port: the sweep owns it during INIT, the user write channel afterwards.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = bus.iv_wr_addr;
        ram_wdata_s = bus.iv_wr_data;
        if (state_q == ST_INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = ptr_q;
            ram_wdata_s = '0;
        end else begin
            ram_we_s    = wr_fire_s;
        end
    end

    // Sweep FSM next state: last sweep write at the top address hands over to RUN.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = ST_INIT;
                end
            end
            ST_RUN:  init_done_d = 1'b1;
            default: state_d     = RST_STATE;
        endcase
    end

    // FIFO occupancy and request credit; credit counts queued plus in-flight responses.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        occ_s       = {1'b0, fifo_cnt_d} + {{CW{1'b0}}, rd_fire_s};
        req_ready_d = init_done_d && (occ_s < OCC_LIMIT);
    end

    // Table storage and read stage; not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[ram_waddr_s] <= ram_wdata_s;
        end
        if (rd_fire_s) begin
            ram_rd_q      <= ram_q[bus.iv_rd_addr];
            s1_fwd_data_q <= bus.iv_wr_data;
        end
    end

    // Control state, read pipeline flags, response FIFO and forward counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            ptr_q       <= '0;
            init_done_q <= RST_DONE;
            req_ready_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_fwd_q    <= 1'b0;
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
            fifo_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            fwd_cnt_q   <= '0;
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            req_ready_q <= req_ready_d;
            s1_vld_q    <= rd_fire_s;
            if (rd_fire_s) begin
                s1_fwd_q <= fwd_hit_s;
            end
            if (push_s) begin
                fifo_mem_q[fifo_wr_q] <= push_data_s;
                fifo_wr_q             <= fifo_wr_q + PW'(1);
            end
            if (pop_s) begin
                fifo_rd_q <= fifo_rd_q + PW'(1);
            end
            fifo_cnt_q  <= fifo_cnt_d;
            rsp_valid_q <= (fifo_cnt_d != '0);
            if (fwd_hit_s && (fwd_cnt_q != 16'hFFFF)) begin
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_init_done    = init_done_q;
    assign bus.o_wr_ready     = init_done_q;
    assign bus.o_rd_req_ready = req_ready_q;
    assign bus.o_rd_rsp_valid = rsp_valid_q;
    assign bus.ov_rd_rsp_data = fifo_mem_q[fifo_rd_q];
    assign bus.ov_fwd_cnt     = fwd_cnt_q;
endmodule
